branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
// Parametrised successor to the combinational branch condition check. Holds an
// architectural flag register {Z,N,C,V} written by the ALU, evaluates 8 branch
// conditions, and keeps a BHT_DEPTH-entry table of 2-bit saturating counters
// that predicts direction at fetch. Resolves branches one cycle after issue,
// flags mispredicts, produces the redirect PC, and counts branches/mispredicts.
// PARAMETERS
// PC_WIDTH    8   width of instruction address
// BHT_DEPTH   16  BHT entries, power of 2, >=2; index = pc[log2(BHT_DEPTH)-1:0]
// CNT_WIDTH   16  width of saturating perf counters
// FLAG_FWD    1   1: a same-cycle flag write is forwarded into evaluation
// PORTS
// i_clk            in   1         clock, all state on rising edge
// i_rst            in   1         synchronous reset, active-high
// i_flags_we       in   1         latch i_flags into flag register
// i_flags          in   4         {Z,N,C,V} from ALU
// i_fetch_pc       in   PC_WIDTH  fetch address for prediction lookup
// o_pred_taken     out  1         combinational: MSB of BHT[i_fetch_pc idx]
// i_br_valid       in   1         branch issued this cycle
// i_cond           in   3         condition select, see below
// i_br_pc          in   PC_WIDTH  address of issued branch
// i_br_target      in   PC_WIDTH  taken target
// i_br_pred        in   1         direction fetch predicted for this branch
// i_flush          in   1         kill branch issued this cycle
// o_res_valid      out  1         resolve result valid (1 cycle after issue)
// o_taken          out  1         resolved direction
// o_mispredict     out  1         o_taken != registered i_br_pred
// o_redirect_pc    out  PC_WIDTH  taken ? target : br_pc+1 (mod 2^PC_WIDTH)
// o_br_count       out  CNT_WIDTH resolved branches
// o_mispred_count  out  CNT_WIDTH mispredicted branches
// BEHAVIOUR
// - Reset: flags=0, all BHT entries=2'b01 (weak not-taken), all o_* regs=0,
//   both counters=0; reset wins over every other input in that cycle.
// - Cond: 000 never, 001 always (JMP), 010 EQ Z, 011 NE ~Z, 100 LT N^V,
//   101 GE ~(N^V), 110 LTU C, 111 GEU ~C.
// - Eval flags: FLAG_FWD=1 and i_flags_we -> i_flags; else flag register.
// - Issue cycle T (i_br_valid & ~i_flush): compute taken, capture pred, pc,
//   target. Cycle T+1: o_res_valid=1 with o_taken/o_mispredict/o_redirect_pc.
//   o_res_valid is a 1-cycle pulse; other result outputs hold until next one.
// - i_flush in T: no result, no BHT update, no count. Back-to-back issue legal.
// - BHT update at edge ending T: taken -> counter+1 sat 11; not taken -> -1
//   sat 00. Conditions 000/001 also train the entry.
// - Same-cycle lookup and update of one index: o_pred_taken shows old value.
// - redirect for not-taken at pc=2^PC_WIDTH-1 wraps to 0.
// - Counters: o_br_count +1 per resolve, o_mispred_count +1 per mispredict;
//   both saturate at all-ones, no wrap.
// - Flag write and branch issue in same cycle: register updates at the edge;
//   FLAG_FWD decides which value the branch sees.
// TESTING
// - Reset, then read every BHT idx via i_fetch_pc -> o_pred_taken=0 all, counts 0.
// - flags_we {Z=1}, next cycle issue cond=011 pc=8'h10 tgt=8'h40 pred=0 ->
//   T+1 taken=0, mispredict=0, redirect=8'h11.
// - Same-cycle flags_we Z=0 + cond=011, FLAG_FWD=1 -> taken=1, redirect=tgt;
//   FLAG_FWD=0 -> evaluates old Z=1, taken=0.
// - 3 taken issues at pc idx 5 -> BHT 01->10->11->11, o_pred_taken=1 after 1st.
// - Issue with i_flush=1 -> no o_res_valid, BHT and counters unchanged; and
//   i_rst asserted during issue -> all outputs 0 next cycle.
// - CNT_WIDTH=2, 5 mispredicts -> both counters stick at 2'b11; pc=8'hFF
//   not-taken -> redirect=8'h00.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: flag register, 8-way condition evaluation, 2-bit BHT
// predictor, one-cycle-latency resolution with redirect PC and perf counters.
module branch_resolve_unit #(
  parameter int PC_WIDTH  = 8,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int FLAG_FWD  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flags_we,
  input  logic [3:0]           i_flags,
  input  logic [PC_WIDTH-1:0]  i_fetch_pc,
  output logic                 o_pred_taken,
  input  logic                 i_br_valid,
  input  logic [2:0]           i_cond,
  input  logic [PC_WIDTH-1:0]  i_br_pc,
  input  logic [PC_WIDTH-1:0]  i_br_target,
  input  logic                 i_br_pred,
  input  logic                 i_flush,
  output logic                 o_res_valid,
  output logic                 o_taken,
  output logic                 o_mispredict,
  output logic [PC_WIDTH-1:0]  o_redirect_pc,
  output logic [CNT_WIDTH-1:0] o_br_count,
  output logic [CNT_WIDTH-1:0] o_mispred_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] bht_step(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    if (up) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  // Perf counter increment that sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  endfunction

  logic [3:0]           flags_q, flags_d;
  logic [1:0]           bht_q [BHT_DEPTH];
  logic [1:0]           bht_d [BHT_DEPTH];
  logic                 res_valid_q, res_valid_d;
  logic                 taken_q, taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [PC_WIDTH-1:0]  redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;

  logic [3:0]           eval_flags_s;
  logic                 cond_base_s;
  logic                 cond_taken_s;
  logic                 issue_s;
  logic [IDX_W-1:0]     br_idx_s;
  logic                 unused_fetch_s;

  assign issue_s        = i_br_valid & ~i_flush;
  assign br_idx_s       = i_br_pc[IDX_W-1:0];
  assign o_pred_taken   = bht_q[i_fetch_pc[IDX_W-1:0]][1];
  assign unused_fetch_s = ^i_fetch_pc;

  // Flags seen by the branch: optionally bypass a same-cycle ALU write.
  always_comb begin
    if ((FLAG_FWD != 0) && i_flags_we) begin
      eval_flags_s = i_flags;
    end else begin
      eval_flags_s = flags_q;
    end
  end

  // Conditions come in complementary pairs; i_cond[0] inverts the base test.
  always_comb begin
    case (i_cond[2:1])
      2'b00:   cond_base_s = 1'b0;
      2'b01:   cond_base_s = eval_flags_s[3];
      2'b10:   cond_base_s = eval_flags_s[2] ^ eval_flags_s[0];
      2'b11:   cond_base_s = eval_flags_s[1];
      default: cond_base_s = 1'b0;
    endcase
    cond_taken_s = cond_base_s ^ i_cond[0];
  end

  // Next-state for flags, predictor table, result registers and counters.
  always_comb begin
    bht_d = bht_q;
    if (i_flags_we) begin
      flags_d = i_flags;
    end else begin
      flags_d = flags_q;
    end
    res_valid_d = issue_s;
    if (issue_s) begin
      taken_d           = cond_taken_s;
      mispredict_d      = cond_taken_s ^ i_br_pred;
      redirect_d        = cond_taken_s ? i_br_target : i_br_pc + PC_ONE;
      bht_d[br_idx_s]   = bht_step(bht_q[br_idx_s], cond_taken_s);
      br_count_d        = cnt_sat_inc(br_count_q);
      if (cond_taken_s ^ i_br_pred) begin
        mispred_count_d = cnt_sat_inc(mispred_count_q);
      end else begin
        mispred_count_d = mispred_count_q;
      end
    end else begin
      taken_d         = taken_q;
      mispredict_d    = mispredict_q;
      redirect_d      = redirect_q;
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
    end
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      flags_q         <= 4'b0000;
      res_valid_q     <= 1'b0;
      taken_q         <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_q      <= {PC_WIDTH{1'b0}};
      br_count_q      <= {CNT_WIDTH{1'b0}};
      mispred_count_q <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      flags_q         <= flags_d;
      res_valid_q     <= res_valid_d;
      taken_q         <= taken_d;
      mispredict_q    <= mispredict_d;
      redirect_q      <= redirect_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign o_res_valid     = res_valid_q;
  assign o_taken         = taken_q;
  assign o_mispredict    = mispredict_q;
  assign o_redirect_pc   = redirect_q;
  assign o_br_count      = br_count_q;
  assign o_mispred_count = mispred_count_q;

endmodule
